serial_nibble_rx: RTL and testbench

SERIAL_NIBBLE_RX -- requirements
Module: serial_nibble_rx

---
 rtl/serial_pkg.sv | 27 ++
 rtl/serial_nibble_rx_bit_timer.sv | 39 +++
 rtl/serial_nibble_rx.sv | 163 ++++++++++++++++
 tb/tb_serial_nibble_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial nibble receiver.
//   state_t              FSM state encodings (IDLE=0 .. STOP=4)
//   START_LVL / STOP_LVL line levels of the start and stop bits
//   CYC_PER_BIT_DEFAULT  default clock cycles per serial bit
//   CNT_W                width of the bit-cycle counter (covers up to 16 cycles)
//   parity_bad()         even-parity check over the nibble plus parity bit
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic        START_LVL           = 1'b1;
  localparam logic        STOP_LVL            = 1'b0;
  localparam int unsigned CYC_PER_BIT_DEFAULT = 4;
  localparam int unsigned CNT_W               = 4;

  // Even parity: the XOR of the four data bits and the parity bit must be 0.
  function automatic logic parity_bad(input logic [3:0] nib, input logic par);
    return ^{nib, par};
  endfunction

endpackage

// File: rtl/serial_nibble_rx_bit_timer.sv
// bit_timer: bit-cycle counter for the serial nibble receiver.
//   clk        rising-edge clock
//   rst        synchronous active-high reset, clears cnt
//   clr        synchronous clear, asserted by the FSM on every state change
//   cnt        cycle position within the current bit (0 .. CYC_PER_BIT-1)
//   half_tick  cnt == CYC_PER_BIT/2-1 (start-bit mid-point)
//   full_tick  cnt == CYC_PER_BIT-1   (data/parity/stop sample point)
// The counter wraps to 0 by itself after full_tick so consecutive data bits
// are timed without a state change.
module bit_timer
  import serial_pkg::*;
#(
  parameter int unsigned CYC_PER_BIT = CYC_PER_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             half_tick,
  output logic             full_tick
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYC_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYC_PER_BIT - 1);

  assign half_tick = (cnt == HALF_LAST);
  assign full_tick = (cnt == FULL_LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/serial_nibble_rx.sv
// serial_nibble_rx: receives a 4-bit nibble from a one-wire serial line.
// Frame: start bit (1), four data bits MSB first, optional even-parity bit,
// stop bit (0). The line idles at 0.
//   clk        rising-edge clock
//   rst        synchronous active-high reset (priority over everything)
//   en         receiver enable; 0 returns to IDLE and drops any partial frame
//   In         serial line
//   data       last correctly received nibble (registered)
//   valid      one-cycle pulse when data is updated
//   frame_err  one-cycle pulse when the stop bit is 1
//   par_err    one-cycle pulse on a parity mismatch (parity build only)
//   busy       high in every state except IDLE
// Build option: define SERIAL_NIBBLE_RX_PARITY_EN to add the parity bit, the
// PARITY state and the par_err port.
module serial_nibble_rx
  import serial_pkg::*;
#(
  parameter int unsigned CYC_PER_BIT = CYC_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       In,
  output logic [3:0] data,
  output logic       valid,
  output logic       frame_err,
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  output logic       par_err,
`endif
  output logic       busy
);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt;
  logic             half_tick;
  logic             full_tick;
  logic             timer_clr;
  logic [1:0]       bcnt_q;
  logic [3:0]       shreg_q;

  logic             data_smp;
  logic             stop_smp;
  logic             stop_ok;
  logic             par_ok;
  logic             valid_d;
  logic             ferr_d;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic             par_smp;
  logic             par_q;
  logic             perr_d;
`endif

  // The timer restarts whenever the FSM moves, so every state begins at cnt=0.
  assign timer_clr = (state_d != state_q);

  bit_timer #(
    .CYC_PER_BIT (CYC_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (timer_clr),
    .cnt       (cnt),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  cnt_in_range: assert property (@(posedge clk) cnt <= CNT_W'(CYC_PER_BIT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (In == START_LVL) state_d = START;
        end
        START: begin
          // A start bit that is gone at its mid-point is a glitch: quietly drop it.
          if (half_tick) state_d = (In == START_LVL) ? DATA : IDLE;
        end
        DATA: begin
          if (full_tick && (bcnt_q == 2'd3)) begin
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
        PARITY: begin
          if (full_tick) state_d = STOP;
        end
`endif
        STOP: begin
          if (full_tick) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / strobe logic
  always_comb begin
    data_smp = en && (state_q == DATA) && full_tick;
    stop_smp = en && (state_q == STOP) && full_tick;
    stop_ok  = (In == STOP_LVL);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    par_smp  = en && (state_q == PARITY) && full_tick;
    par_ok   = !parity_bad(shreg_q, par_q);
    perr_d   = stop_smp && !par_ok;
`else
    par_ok   = 1'b1;
`endif
    valid_d  = stop_smp && stop_ok && par_ok;
    ferr_d   = stop_smp && !stop_ok;
    busy     = (state_q != IDLE);
  end

  // Datapath and registered pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_q    <= '0;
      shreg_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      par_q     <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      valid     <= valid_d;
      frame_err <= ferr_d;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
      par_err   <= perr_d;
      if (par_smp) par_q <= In;
`endif
      if (valid_d) data <= shreg_q;
      if (data_smp) shreg_q <= {shreg_q[2:0], In};
      // bcnt only matters inside DATA; holding it at 0 elsewhere gives each
      // frame a fresh count on entry.
      if (state_q != DATA) begin
        bcnt_q <= '0;
      end else if (data_smp) begin
        bcnt_q <= bcnt_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_serial_nibble_rx.sv
// tb_serial_nibble_rx: directed self-checking bench for serial_nibble_rx
// with CYC_PER_BIT=4. Outputs are sampled 1 time unit after the rising edge;
// pulse counters are kept on the falling edge. In a parity build the frame
// helper inserts the correct even-parity bit automatically.
module tb_serial_nibble_rx;

  localparam int unsigned CYC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       In;
  logic [3:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  logic       par_err;
  int         perr_cnt = 0;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int busy_cnt    = 0;
  int both_cnt    = 0;

  always #5 clk = ~clk;

  serial_nibble_rx #(
    .CYC_PER_BIT (CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .In        (In),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    .par_err   (par_err),
`endif
    .busy      (busy)
  );

  always @(negedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (frame_err === 1'b1) ferr_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (valid === 1'b1 && frame_err === 1'b1) both_cnt++;
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    if (par_err === 1'b1) perr_cnt++;
`endif
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    In = b;
    step(CYC);
  endtask

  task automatic send_head(input logic [3:0] d);
    send_bit(1'b1);
    for (int i = 3; i >= 0; i--) send_bit(d[i]);
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    send_bit(^d);
`endif
  endtask

  task automatic send_frame(input logic [3:0] d, input logic stop_b);
    send_head(d);
    send_bit(stop_b);
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; In = 1'b0;
    step(2);
    vectors++; if (data !== 4'b0000) begin miscompares++; $display("FAIL reset_data got %b want 0000", data); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0; en = 1'b1;
    step(2);
  endtask

  task automatic test_good_frame;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_head(4'b1011);
    In = 1'b0;
    step(3);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL good_valid_pulse got %b want 1", valid); end
    vectors++; if (data !== 4'b1011) begin miscompares++; $display("FAIL good_data got %b want 1011", data); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL good_ferr got %b want 0", frame_err); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL good_busy_idle got %b want 0", busy); end
    step(1);
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL good_valid_width got %b want 0", valid); end
    step(4);
    vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL good_valid_count got %0d want 1", valid_cnt - v0); end
    vectors++; if (ferr_cnt - f0 != 0) begin miscompares++; $display("FAIL good_ferr_count got %0d want 0", ferr_cnt - f0); end
  endtask

  task automatic test_glitch;
    int b0, v0, f0;
    b0 = busy_cnt; v0 = valid_cnt; f0 = ferr_cnt;
    In = 1'b1;
    step(1);
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_start got %b want 1", busy); end
    In = 1'b0;
    step(2);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL glitch_back_idle got %b want 0", busy); end
    step(3);
    vectors++; if (busy_cnt - b0 != 2) begin miscompares++; $display("FAIL glitch_busy_cycles got %0d want 2", busy_cnt - b0); end
    vectors++; if ((valid_cnt - v0) + (ferr_cnt - f0) != 0) begin miscompares++; $display("FAIL glitch_pulses got %0d want 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
  endtask

  task automatic test_frame_err;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_head(4'b0110);
    In = 1'b1;
    step(3);
    vectors++; if (frame_err !== 1'b1) begin miscompares++; $display("FAIL ferr_pulse got %b want 1", frame_err); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ferr_valid got %b want 0", valid); end
    vectors++; if (data !== 4'b1011) begin miscompares++; $display("FAIL ferr_data_held got %b want 1011", data); end
    step(1);
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL ferr_width got %b want 0", frame_err); end
    In = 1'b0;
    step(6);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_idle got %b want 0", busy); end
    vectors++; if (ferr_cnt - f0 != 1) begin miscompares++; $display("FAIL ferr_count got %0d want 1", ferr_cnt - f0); end
    vectors++; if (valid_cnt - v0 != 0) begin miscompares++; $display("FAIL ferr_valid_count got %0d want 0", valid_cnt - v0); end
  endtask

  task automatic test_en_drop;
    int v0, f0;
    v0 = valid_cnt; f0 = ferr_cnt;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    In = 1'b0;          // third data bit
    step(1);
    en = 1'b0;
    step(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL endrop_idle got %b want 0", busy); end
    vectors++; if (data !== 4'b1011) begin miscompares++; $display("FAIL endrop_data_held got %b want 1011", data); end
    step(3);
    en = 1'b1;
    step(2);
    vectors++; if ((valid_cnt - v0) + (ferr_cnt - f0) != 0) begin miscompares++; $display("FAIL endrop_pulses got %0d want 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
    send_frame(4'b0011, 1'b0);
    step(2);
    vectors++; if (data !== 4'b0011) begin miscompares++; $display("FAIL endrop_next_data got %b want 0011", data); end
    vectors++; if (valid_cnt - v0 != 1) begin miscompares++; $display("FAIL endrop_valid_count got %0d want 1", valid_cnt - v0); end
  endtask

  // The recovery frame carries four 1 data bits (start 1, 1111, stop 0).
  task automatic test_reset_mid;
    int v0, f0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    v0 = valid_cnt; f0 = ferr_cnt;
    rst = 1'b1;
    step(1);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b want 0", busy); end
    vectors++; if (data !== 4'b0000) begin miscompares++; $display("FAIL rstmid_data got %b want 0000", data); end
    vectors++; if (valid !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL rstmid_pulses got %b%b want 00", valid, frame_err); end
    rst = 1'b0; In = 1'b0;
    step(2);
    vectors++; if ((valid_cnt - v0) + (ferr_cnt - f0) != 0) begin miscompares++; $display("FAIL rstmid_no_pulse got %0d want 0", (valid_cnt - v0) + (ferr_cnt - f0)); end
    send_frame(4'b1111, 1'b0);
    step(2);
    vectors++; if (data !== 4'b1111) begin miscompares++; $display("FAIL rstmid_next_data got %b want 1111", data); end
  endtask

  task automatic test_idle_en_low;
    int b0;
    b0 = busy_cnt;
    en = 1'b0; In = 1'b1;
    step(3);
    In = 1'b0;
    step(1);
    en = 1'b1;
    step(2);
    vectors++; if (busy_cnt - b0 != 0) begin miscompares++; $display("FAIL en_low_ignored got %0d busy cycles want 0", busy_cnt - b0); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(4'b1011, 1'b0);
    vectors++; if (data !== 4'b1011) begin miscompares++; $display("FAIL b2b_first got %b want 1011", data); end
    send_frame(4'b0001, 1'b0);
    In = 1'b0;
    step(2);
    vectors++; if (data !== 4'b0001) begin miscompares++; $display("FAIL b2b_second got %b want 0001", data); end
    vectors++; if (valid_cnt - v0 != 2) begin miscompares++; $display("FAIL b2b_valid_count got %0d want 2", valid_cnt - v0); end
  endtask

`ifdef SERIAL_NIBBLE_RX_PARITY_EN
  task automatic test_parity;
    int p0;
    p0 = perr_cnt;
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0);     // wrong parity for 1011
    In = 1'b0;
    step(3);
    vectors++; if (par_err !== 1'b1) begin miscompares++; $display("FAIL par_bad_pulse got %b want 1", par_err); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL par_bad_valid got %b want 0", valid); end
    step(3);
    send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1);     // correct parity
    In = 1'b0;
    step(3);
    vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL par_ok_valid got %b want 1", valid); end
    vectors++; if (data !== 4'b1011) begin miscompares++; $display("FAIL par_ok_data got %b want 1011", data); end
    vectors++; if (par_err !== 1'b0) begin miscompares++; $display("FAIL par_ok_perr got %b want 0", par_err); end
    step(3);
    vectors++; if (perr_cnt - p0 != 1) begin miscompares++; $display("FAIL par_count got %0d want 1", perr_cnt - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_en_drop();
    test_reset_mid();
    test_idle_en_low();
    test_back_to_back();
`ifdef SERIAL_NIBBLE_RX_PARITY_EN
    test_parity();
`endif
    vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL valid_and_ferr_overlap got %0d want 0", both_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
